// File: rtl/maze_pkg.sv
// maze_pkg: shared definitions for the maze-generation datapath.
//   - seq_state_e: wall_clear_sequencer FSM states (IDLE, DRIVE, GAP)
//   - WALL_N/E/S/W: bit positions of each wall inside a wall mask
//   - DEFAULT_WIDTH / DEFAULT_SELECT_WIDTH: defaults shared with the cell-select demultiplexer
package maze_pkg;

  localparam int WALL_N = 0;
  localparam int WALL_E = 1;
  localparam int WALL_S = 2;
  localparam int WALL_W = 3;

  localparam int DEFAULT_WIDTH        = 4;
  localparam int DEFAULT_SELECT_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/wall_req_fifo.sv
// wall_req_fifo: small synchronous FIFO holding pending wall-clear requests.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears pointers/count)
//   push        : write push_data (ignored when full)
//   pop         : drop the head entry (ignored when empty)
//   push_data   : entry to write
//   head        : current head entry (valid while !empty)
//   count       : number of stored entries, 0..DEPTH
//   empty       : count == 0
module wall_req_fifo
  import maze_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ENTRY_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_WIDTH-1:0]   push_data,
  output logic [ENTRY_WIDTH-1:0]   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE_C   = CW'(1);
  localparam logic [PW-1:0] PTR_ONE_C   = PW'(1);

  logic [ENTRY_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]          wr_ptr_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [CW-1:0]          count_r;
  logic                   push_ok_s;
  logic                   pop_ok_s;

  // Qualify push/pop against the current occupancy; full blocks a push even with a same-edge pop.
  always_comb begin
    push_ok_s = push && (count_r < CNT_DEPTH_C);
    pop_ok_s  = pop && (count_r != {CW{1'b0}});
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates their use.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/wall_clear_sequencer.sv
// wall_clear_sequencer: buffers wall-clear requests and replays each one onto the
// cell-select demultiplexer for HOLD_CYCLES cycles followed by one all-zero gap cycle.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   req_valid    : request present          req_ready : FIFO can accept (count < DEPTH)
//   req_index    : target cell              req_mask  : walls to clear (bit0 N,1 E,2 S,3 W)
//   wr_data      : demux data (mask in DRIVE, zero otherwise)
//   wr_index     : demux select, updated only on DRIVE entry
//   wr_active    : high while wr_data carries a mask
//   busy         : FIFO non-empty or FSM not IDLE
//   clear_count  : saturating count of driven requests (only with WALL_CLEAR_STATS_EN)
// Build option: define WALL_CLEAR_STATS_EN to add the clear_count port and counter.
module wall_clear_sequencer
  import maze_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int SELECT_WIDTH = DEFAULT_SELECT_WIDTH,
  parameter int DEPTH        = 4,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [SELECT_WIDTH-1:0] req_index,
  input  logic [WIDTH-1:0]        req_mask,
  output logic [WIDTH-1:0]        wr_data,
  output logic [SELECT_WIDTH-1:0] wr_index,
  output logic                    wr_active,
  output logic                    busy
`ifdef WALL_CLEAR_STATS_EN
  ,
  output logic [15:0]             clear_count
`endif
);

  localparam int EW = SELECT_WIDTH + WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_DEPTH_C = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LOAD_C = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE_C  = HW'(1);

  seq_state_e              state_r;
  logic [HW-1:0]           hold_r;
  logic [WIDTH-1:0]        wr_data_r;
  logic [SELECT_WIDTH-1:0] wr_index_r;
  logic                    wr_active_r;

  logic [EW-1:0]           head_s;
  logic [WIDTH-1:0]        head_mask_s;
  logic [SELECT_WIDTH-1:0] head_index_s;
  logic [CW-1:0]           count_s;
  logic                    empty_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    load_s;

  wall_req_fifo #(
    .DEPTH       (DEPTH),
    .ENTRY_WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .push_data ({req_index, req_mask}),
    .head      (head_s),
    .count     (count_s),
    .empty     (empty_s)
  );

  // Handshake and head decode; IDLE pops every entry, but only non-zero masks start a DRIVE.
  always_comb begin
    req_ready    = (count_s < CNT_DEPTH_C);
    push_s       = req_valid && req_ready;
    head_mask_s  = head_s[WIDTH-1:0];
    head_index_s = head_s[EW-1:WIDTH];
    pop_s        = (state_r == IDLE) && !empty_s;
    load_s       = pop_s && (head_mask_s != {WIDTH{1'b0}});
  end

  // Replay FSM with registered demux outputs; wr_index is left untouched outside DRIVE entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      hold_r      <= {HW{1'b0}};
      wr_data_r   <= {WIDTH{1'b0}};
      wr_index_r  <= {SELECT_WIDTH{1'b0}};
      wr_active_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (load_s) begin
            state_r     <= DRIVE;
            hold_r      <= HOLD_LOAD_C;
            wr_data_r   <= head_mask_s;
            wr_index_r  <= head_index_s;
            wr_active_r <= 1'b1;
          end
        end
        DRIVE: begin
          if (hold_r == {HW{1'b0}}) begin
            state_r     <= GAP;
            wr_data_r   <= {WIDTH{1'b0}};
            wr_active_r <= 1'b0;
          end else begin
            hold_r <= hold_r - HOLD_ONE_C;
          end
        end
        GAP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          wr_data_r   <= {WIDTH{1'b0}};
          wr_active_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef WALL_CLEAR_STATS_EN
  logic [15:0] clear_count_r;

  // Saturating count of IDLE->DRIVE transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      clear_count_r <= 16'h0000;
    end else if (load_s && (clear_count_r != 16'hFFFF)) begin
      clear_count_r <= clear_count_r + 16'h0001;
    end
  end

  assign clear_count = clear_count_r;
`endif

  assign wr_data   = wr_data_r;
  assign wr_index  = wr_index_r;
  assign wr_active = wr_active_r;
  assign busy      = !empty_s || (state_r != IDLE);

endmodule

// File: tb/tb_wall_clear_sequencer.sv
// Directed bench for wall_clear_sequencer: two instances, HOLD_CYCLES=1 (u_a) and 3 (u_b).
module tb_wall_clear_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       a_req_valid, a_req_ready, a_wr_active, a_busy;
  logic [5:0] a_req_index, a_wr_index;
  logic [3:0] a_req_mask, a_wr_data;
  logic       b_req_valid, b_req_ready, b_wr_active, b_busy;
  logic [5:0] b_req_index, b_wr_index;
  logic [3:0] b_req_mask, b_wr_data;
`ifdef WALL_CLEAR_STATS_EN
  logic [15:0] a_clear_count, b_clear_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Masks captured on each rising edge of wr_active: {index, data}
  logic [9:0] got_a[$];
  logic [9:0] got_b[$];
  logic a_prev, b_prev;

  always #5 clk = ~clk;

  wall_clear_sequencer #(.WIDTH(4), .SELECT_WIDTH(6), .DEPTH(4), .HOLD_CYCLES(1)) u_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_index(a_req_index), .req_mask(a_req_mask),
    .wr_data(a_wr_data), .wr_index(a_wr_index),
    .wr_active(a_wr_active), .busy(a_busy)
`ifdef WALL_CLEAR_STATS_EN
    , .clear_count(a_clear_count)
`endif
  );

  wall_clear_sequencer #(.WIDTH(4), .SELECT_WIDTH(6), .DEPTH(4), .HOLD_CYCLES(3)) u_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_index(b_req_index), .req_mask(b_req_mask),
    .wr_data(b_wr_data), .wr_index(b_wr_index),
    .wr_active(b_wr_active), .busy(b_busy)
`ifdef WALL_CLEAR_STATS_EN
    , .clear_count(b_clear_count)
`endif
  );

  // Record every mask the demux is handed, in order.
  always @(negedge clk) begin
    if (reset) begin
      a_prev <= 1'b0;
      b_prev <= 1'b0;
    end else begin
      if (a_wr_active && !a_prev) got_a.push_back({a_wr_index, a_wr_data});
      if (b_wr_active && !b_prev) got_b.push_back({b_wr_index, b_wr_data});
      a_prev <= a_wr_active;
      b_prev <= b_wr_active;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request and hold it until accepted; waited = cycles spent with req_ready low.
  task automatic push_req(input logic sel_b, input logic [5:0] idx, input logic [3:0] m,
                          output int waited);
    waited = 0;
    if (sel_b) begin
      b_req_valid = 1'b1; b_req_index = idx; b_req_mask = m;
    end else begin
      a_req_valid = 1'b1; a_req_index = idx; a_req_mask = m;
    end
    while (!(sel_b ? b_req_ready : a_req_ready) && waited < 50) begin
      step();
      waited++;
    end
    if (waited >= 50) begin
      check("push_timeout", 32'd0, 32'd1);
    end else begin
      step();
    end
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input logic sel_b);
    int n;
    n = 0;
    while ((sel_b ? b_busy : a_busy) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [9:0] e;
    logic [3:0] exp_data [10];
    logic       exp_busy [10];
    exp_data = '{4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    a_req_valid = 1'b0; a_req_index = 6'd0; a_req_mask = 4'd0;
    b_req_valid = 1'b0; b_req_index = 6'd0; b_req_mask = 4'd0;

    // Reset state
    step();
    step();
    check("rst_wr_data",   32'(a_wr_data),   32'd0);
    check("rst_wr_index",  32'(a_wr_index),  32'd0);
    check("rst_wr_active", 32'(a_wr_active), 32'd0);
    check("rst_busy",      32'(a_busy),      32'd0);
    check("rst_b_busy",    32'(b_busy),      32'd0);
    reset = 1'b0;
    step();
    check("rst_ready",     32'(a_req_ready), 32'd1);
`ifdef WALL_CLEAR_STATS_EN
    check("rst_count", 32'(a_clear_count), 32'd0);
`endif

    // Single request, HOLD_CYCLES=1
    push_req(1'b0, 6'd5, 4'b0011, w);
    check("t1_busy_e0",   32'(a_busy),      32'd1);
    check("t1_active_e0", 32'(a_wr_active), 32'd0);
    step();
    check("t1_active_e1", 32'(a_wr_active), 32'd1);
    check("t1_index_e1",  32'(a_wr_index),  32'd5);
    check("t1_data_e1",   32'(a_wr_data),   32'h3);
    step();
    check("t1_gap_data",   32'(a_wr_data),   32'd0);
    check("t1_gap_active", 32'(a_wr_active), 32'd0);
    check("t1_gap_busy",   32'(a_busy),      32'd1);
    step();
    check("t1_done_busy",  32'(a_busy),      32'd0);
    check("t1_hold_index", 32'(a_wr_index),  32'd5);
`ifdef WALL_CLEAR_STATS_EN
    check("t1_count", 32'(a_clear_count), 32'd1);
`endif

    // Back-to-back requests, HOLD_CYCLES=3
    got_b.delete();
    push_req(1'b1, 6'd3, 4'b1000, w);
    push_req(1'b1, 6'd7, 4'b0100, w);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      check($sformatf("t2_data_%0d", i),   32'(b_wr_data),   32'(exp_data[i]));
      check($sformatf("t2_active_%0d", i), 32'(b_wr_active), 32'(exp_data[i] != 4'h0));
      check($sformatf("t2_busy_%0d", i),   32'(b_busy),      32'(exp_busy[i]));
    end
    check("t2_n", 32'(got_b.size()), 32'd2);
    if (got_b.size() == 2) begin
      check("t2_first",  32'(got_b[0]), 32'({6'd3, 4'b1000}));
      check("t2_second", 32'(got_b[1]), 32'({6'd7, 4'b0100}));
    end

    // FIFO fills while the FSM is held in a long DRIVE
    got_b.delete();
    for (int i = 0; i < 5; i++) begin
      push_req(1'b1, 6'(10 + i), 4'(1 + i), w);
      check($sformatf("t3_wait_%0d", i), 32'(w), 32'd0);
    end
    check("t3_full_ready", 32'(b_req_ready), 32'd0);
    push_req(1'b1, 6'd15, 4'd6, w);
    check("t3_sixth_wait", 32'(w), 32'd2);
    wait_idle(1'b1);
    check("t3_n", 32'(got_b.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      e = {6'(10 + i), 4'(1 + i)};
      if (i < got_b.size()) check($sformatf("t3_order_%0d", i), 32'(got_b[i]), 32'(e));
    end
`ifdef WALL_CLEAR_STATS_EN
    check("t3_count", 32'(b_clear_count), 32'd8);
`endif

    // Zero-mask request is discarded in one IDLE cycle
    got_a.delete();
    push_req(1'b0, 6'd9, 4'b0000, w);
    push_req(1'b0, 6'd2, 4'b0001, w);
    check("t4_active_e1", 32'(a_wr_active), 32'd0);
    step();
    check("t4_active_e2", 32'(a_wr_active), 32'd1);
    check("t4_index_e2",  32'(a_wr_index),  32'd2);
    check("t4_data_e2",   32'(a_wr_data),   32'h1);
    wait_idle(1'b0);
    check("t4_n", 32'(got_a.size()), 32'd1);
    if (got_a.size() == 1) check("t4_entry", 32'(got_a[0]), 32'({6'd2, 4'b0001}));

    // Reset during DRIVE with two entries queued
    push_req(1'b1, 6'd20, 4'h1, w);
    push_req(1'b1, 6'd21, 4'h2, w);
    push_req(1'b1, 6'd22, 4'h4, w);
    check("t5_active", 32'(b_wr_active), 32'd1);
    check("t5_index",  32'(b_wr_index),  32'd20);
    reset = 1'b1;
    step();
    check("t5_rst_data",   32'(b_wr_data),   32'd0);
    check("t5_rst_active", 32'(b_wr_active), 32'd0);
    check("t5_rst_busy",   32'(b_busy),      32'd0);
    check("t5_rst_ready",  32'(b_req_ready), 32'd1);
`ifdef WALL_CLEAR_STATS_EN
    check("t5_rst_count", 32'(b_clear_count), 32'd0);
`endif
    reset = 1'b0;
    got_b.delete();
    repeat (12) step();
    check("t5_no_replay", 32'(got_b.size()), 32'd0);
    check("t5_idle_busy", 32'(b_busy),       32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
